mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle successor to the single-cycle main decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives per-cycle datapath enables. It adds a memory-acknowledge handshake and parametrised multiply/divide busy-waiting. It sits between the instruction register (op/func) and the shared multi-cycle datapath.

## Interface
- MULT_CYCLES, 5: cycles spent in MDWAIT for mult (1..15)
- DIV_CYCLES, 10: cycles spent in MDWAIT for div (1..15)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  6  IR[31:26], stable from DECODE until the next FETCH
- func  in  6  IR[5:0], same validity as op
- mem_ack  in  1  memory access complete this cycle
- zero  in  1  datapath rs==rt
- lez  in  1  datapath rs<=0 (signed)
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrc, ExtOp  out  1 each
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemtoReg  out  2  00 ALU, 01 lui imm, 10 mem, 11 PC+4
- ALUCtrl  out  3  010 add, 011 sub, 001 or, 111 none
- NPCSel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
- MDOp  out  2  00 none, 01 mult start, 10 div start (one-cycle pulse)
- HiLoRd  out  2  00 none, 10 hi, 01 lo (overrides MemtoReg in WB)
- illegal  out  1  one-cycle pulse on an unknown op/func
- state  out  3  current state encoding

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5. Outputs are combinational from state, op, func, zero and lez. Any output not listed in a state is 0.
- FETCH: MemRead=1.
  - No mem_ack: stay in FETCH.
  - mem_ack: IRWrite=1, PCWrite=1, NPCSel=00, go to DECODE.
- DECODE:
  - jal: RegWrite=1, RegDst=10, MemtoReg=11, PCWrite=1, NPCSel=10, go to FETCH.
  - Unknown op, or unknown func with op=0: illegal=1, go to FETCH.
  - Otherwise: go to EXEC.
- EXEC:
  - addu: ALUCtrl=010, go to WB.
  - subu: ALUCtrl=011, go to WB.
  - ori: ALUSrc=1, ExtOp=1, ALUCtrl=001, go to WB.
  - lui: go to WB.
  - lw/sw: ALUSrc=1, ExtOp=0, ALUCtrl=010, go to MEM.
  - beq: ALUCtrl=011, PCWrite=zero, NPCSel=01, go to FETCH.
  - blez: PCWrite=lez, NPCSel=01, go to FETCH.
  - jr: PCWrite=1, NPCSel=11, RegWrite=0, go to FETCH.
  - mult/div: MDOp pulse, counter loaded with MULT_CYCLES-1 or DIV_CYCLES-1, go to MDWAIT.
  - mfhi/mflo: go to WB.
- MEM:
  - lw: MemRead=1; on mem_ack go to WB.
  - sw: MemWrite=1; on mem_ack go to FETCH.
  - Stay in MEM while mem_ack=0.
- WB: RegWrite=1 for exactly one cycle, then FETCH.
  - RegDst=01 for R-type, 00 for ori/lui/lw.
  - MemtoReg=10 for lw, 01 for lui, else 00.
  - HiLoRd=10 for mfhi, 01 for mflo.
- MDWAIT: counter decrements each cycle; at 0, go to FETCH.
- Counter is 4 bits; it never wraps (decrements only while nonzero).
- Undefined state encodings 6–7 return to FETCH on the next edge.

## Timing
- While reset is asserted: state=FETCH, counter=0, and every output is forced to 0.
- First MemRead=1 appears in the first cycle after reset deasserts.
- Minimum cycles per instruction, with mem_ack immediate:
  - jal: 2
  - beq/blez/jr: 3
  - sw: 4
  - ALU ops and mfhi/mflo: 4
  - lw: 5
  - mult: 3+MULT_CYCLES
  - div: 3+DIV_CYCLES
- mem_ack is sampled only in FETCH and MEM and ignored elsewhere. Each extra cycle mem_ack is held low adds exactly one cycle.
- Reset asserted mid-instruction aborts it immediately. No partial RegWrite/MemWrite occurs after the reset edge.

## Configuration
- MC_MULTDIV_EN defined: mult/div/mfhi/mflo are decoded, MDWAIT is reachable, and the MDOp/HiLoRd outputs are live.
- MC_MULTDIV_EN undefined: those four instructions raise illegal in DECODE. MDOp and HiLoRd are tied to 0, and the counter and MDWAIT logic are absent.

## Structure
- Shared package holds:
  - state encodings
  - opcode/func constants: addu 100001, subu 100011, jr 001000, mult 011000, div 011010, mfhi 010000, mflo 010010, lw 100011, sw 101011, beq 000100, blez 000110, lui 001111, ori 001101, jal 000011
  - ALUCtrl, RegDst, MemtoReg and NPCSel codes
- One sub-module, mc_decode: purely combinational op/func classification into an instruction-class vector. The FSM consumes that vector.

## Test plan
- Reset pulse held 3 cycles, then released, mem_ack=1: all outputs 0 during reset; state 0→1 and MemRead=1 in the first cycle after release.
- addu (op=0, func=100001), mem_ack=1: states 0,1,2,4,0; RegWrite=1 only in WB, with RegDst=01.
- lw with mem_ack low for 2 extra cycles in MEM: MemRead stays 1 for 3 MEM cycles; 7 cycles total; MemtoReg=10 in WB.
- beq with zero=0, then beq with zero=1: PCWrite=0 in EXEC, then PCWrite=1 with NPCSel=01.
- mult with MULT_CYCLES=5 and MC_MULTDIV_EN defined: MDOp=01 for one cycle; MDWAIT lasts 5 cycles; 8 cycles total. With the macro undefined: illegal=1 in DECODE.
- jal, then reset asserted in DECODE of the following sw: jal asserts RegDst=10, MemtoReg=11, NPCSel=10; reset forces MemWrite=0 and state=FETCH.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multi-cycle main controller: state encodings,
// opcode/func constants, instruction classes and datapath select codes.
package mc_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [3:0] {
    IC_ILLEGAL, IC_ADDU, IC_SUBU, IC_ORI, IC_LUI, IC_LW, IC_SW, IC_BEQ,
    IC_BLEZ, IC_JR, IC_JAL, IC_MULT, IC_DIV, IC_MFHI, IC_MFLO
  } iclass_t;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_NONE = 3'b111;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_LUI = 2'b01;
  localparam logic [1:0] M2R_MEM = 2'b10;
  localparam logic [1:0] M2R_PC4 = 2'b11;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_RS  = 2'b11;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam logic [1:0] HL_NONE = 2'b00;
  localparam logic [1:0] HL_HI   = 2'b10;
  localparam logic [1:0] HL_LO   = 2'b01;

  // R-type results are written to rd; everything else that writes back uses rt
  function automatic logic is_rtype(input iclass_t c);
    return (c == IC_ADDU) || (c == IC_SUBU) || (c == IC_MFHI) || (c == IC_MFLO);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func classification into an instruction class.
// mult/div/mfhi/mflo are only recognised when MC_MULTDIV_EN is defined.
module mc_decode
  import mc_controller_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    iclass
);

  always_comb begin
    iclass = IC_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: iclass = IC_ADDU;
          FN_SUBU: iclass = IC_SUBU;
          FN_JR:   iclass = IC_JR;
`ifdef MC_MULTDIV_EN
          FN_MULT: iclass = IC_MULT;
          FN_DIV:  iclass = IC_DIV;
          FN_MFHI: iclass = IC_MFHI;
          FN_MFLO: iclass = IC_MFLO;
`endif
          default: iclass = IC_ILLEGAL;
        endcase
      end
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      OP_BEQ:  iclass = IC_BEQ;
      OP_BLEZ: iclass = IC_BLEZ;
      OP_LUI:  iclass = IC_LUI;
      OP_ORI:  iclass = IC_ORI;
      OP_JAL:  iclass = IC_JAL;
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory handshake. MC_MULTDIV_EN enables mult/div busy-waiting and hi/lo reads.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       mem_ack,
  input  logic       zero,
  input  logic       lez,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [2:0] ALUCtrl,
  output logic [1:0] NPCSel,
  output logic [1:0] MDOp,
  output logic [1:0] HiLoRd,
  output logic       illegal,
  output logic [2:0] state
);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 15 || DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_cycles
    $error("mc_controller: MULT_CYCLES/DIV_CYCLES must be in 1..15");
  end

  state_t  state_q, state_d;
  iclass_t iclass;

  mc_decode u_decode (
    .op     (op),
    .func   (func),
    .iclass (iclass)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

`ifdef MC_MULTDIV_EN
  logic [3:0] md_count;
  logic       md_load;
  logic [3:0] md_load_val;

  // Busy counter: loaded on the EXEC that issues mult/div, saturates at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         md_count <= '0;
    else if (md_load)                                  md_count <= md_load_val;
    else if (state_q == S_MDWAIT && md_count != 4'd0)  md_count <= md_count - 4'd1;
  end
`else
  assign MDOp   = MD_NONE;
  assign HiLoRd = HL_NONE;
`endif

  always_comb begin
    state_d  = S_FETCH;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    RegDst   = RD_RT;
    MemtoReg = M2R_ALU;
    ALUCtrl  = 3'b000;
    NPCSel   = NPC_SEQ;
    illegal  = 1'b0;
`ifdef MC_MULTDIV_EN
    MDOp        = MD_NONE;
    HiLoRd      = HL_NONE;
    md_load     = 1'b0;
    md_load_val = '0;
`endif

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ack) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          NPCSel  = NPC_SEQ;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      // jal completes here by linking PC+4 into $31 while jumping
      S_DECODE: begin
        if (iclass == IC_JAL) begin
          RegWrite = 1'b1;
          RegDst   = RD_RA;
          MemtoReg = M2R_PC4;
          PCWrite  = 1'b1;
          NPCSel   = NPC_J;
          state_d  = S_FETCH;
        end else if (iclass == IC_ILLEGAL) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (iclass)
          IC_ADDU: begin ALUCtrl = ALU_ADD; state_d = S_WB; end
          IC_SUBU: begin ALUCtrl = ALU_SUB; state_d = S_WB; end
          IC_ORI: begin
            ALUSrc  = 1'b1;
            ExtOp   = 1'b1;
            ALUCtrl = ALU_OR;
            state_d = S_WB;
          end
          IC_LUI: state_d = S_WB;
          IC_LW, IC_SW: begin
            ALUSrc  = 1'b1;
            ALUCtrl = ALU_ADD;
            state_d = S_MEM;
          end
          IC_BEQ: begin
            ALUCtrl = ALU_SUB;
            PCWrite = zero;
            NPCSel  = NPC_BR;
          end
          IC_BLEZ: begin
            PCWrite = lez;
            NPCSel  = NPC_BR;
          end
          IC_JR: begin
            PCWrite = 1'b1;
            NPCSel  = NPC_RS;
          end
`ifdef MC_MULTDIV_EN
          IC_MULT: begin
            MDOp        = MD_MULT;
            md_load     = 1'b1;
            md_load_val = 4'(MULT_CYCLES - 1);
            state_d     = S_MDWAIT;
          end
          IC_DIV: begin
            MDOp        = MD_DIV;
            md_load     = 1'b1;
            md_load_val = 4'(DIV_CYCLES - 1);
            state_d     = S_MDWAIT;
          end
          IC_MFHI, IC_MFLO: state_d = S_WB;
`endif
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (iclass == IC_LW) begin
          MemRead = 1'b1;
          state_d = mem_ack ? S_WB : S_MEM;
        end else if (iclass == IC_SW) begin
          MemWrite = 1'b1;
          state_d  = mem_ack ? S_FETCH : S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_rtype(iclass) ? RD_RD : RD_RT;
        if (iclass == IC_LW)       MemtoReg = M2R_MEM;
        else if (iclass == IC_LUI) MemtoReg = M2R_LUI;
`ifdef MC_MULTDIV_EN
        if (iclass == IC_MFHI)      HiLoRd = HL_HI;
        else if (iclass == IC_MFLO) HiLoRd = HL_LO;
`endif
        state_d = S_FETCH;
      end

`ifdef MC_MULTDIV_EN
      S_MDWAIT: state_d = (md_count == 4'd0) ? S_FETCH : S_MDWAIT;
`endif

      default: state_d = S_FETCH;
    endcase

    // Reset silences the datapath so an aborted instruction cannot write anything
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      ALUSrc   = 1'b0;
      ExtOp    = 1'b0;
      RegDst   = RD_RT;
      MemtoReg = M2R_ALU;
      ALUCtrl  = 3'b000;
      NPCSel   = NPC_SEQ;
      illegal  = 1'b0;
`ifdef MC_MULTDIV_EN
      MDOp     = MD_NONE;
      HiLoRd   = HL_NONE;
`endif
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: an instruction-level model expands each
// instruction into its expected per-cycle output trace, checked every negedge.
module tb_mc_controller;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 3;
`ifdef MC_MULTDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic       mem_ack = 1'b1, zero = 1'b0, lez = 1'b0;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrc, ExtOp, illegal;
  logic [1:0] RegDst, MemtoReg, NPCSel, MDOp, HiLoRd;
  logic [2:0] ALUCtrl, state;

  mc_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .mem_ack(mem_ack),
    .zero(zero), .lez(lez), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .ExtOp(ExtOp), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUCtrl(ALUCtrl), .NPCSel(NPCSel), .MDOp(MDOp), .HiLoRd(HiLoRd),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, ext_op;
    logic [1:0] reg_dst, mem_to_reg;
    logic [2:0] alu_ctrl;
    logic [1:0] npc_sel, md_op, hilo_rd;
    logic       ill;
  } obs_t;

  obs_t  act;
  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [5:0] cur_op = '0, cur_func = '0;
  logic       cur_zero = 1'b0, cur_lez = 1'b0;

  assign act = {state, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrc, ExtOp,
                RegDst, MemtoReg, ALUCtrl, NPCSel, MDOp, HiLoRd, illegal};

  task automatic check_output(input string nm, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", nm, actual, expected);
    end
  endtask

  // Compare process: every queued expectation belongs to exactly one cycle
  always @(negedge clk) begin
    obs_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_output(t, 32'(act), 32'(e));
    end
  end

  task automatic apply_stimulus(input obs_t e, input logic ack, input logic rst, input string t);
    @(posedge clk);
    #1;
    reset   = rst;
    mem_ack = ack;
    op      = cur_op;
    func    = cur_func;
    zero    = cur_zero;
    lez     = cur_lez;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input logic l);
    cur_op = o; cur_func = f; cur_zero = z; cur_lez = l;
  endtask

  // Instruction-level model: builds the whole expected trace from the instruction's rules
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input int fetch_wait, input int mem_wait,
                           input logic z, input logic l, output int cycles);
    obs_t e;
    bit is_md    = (name == "mult") || (name == "div") || (name == "mfhi") || (name == "mflo");
    bit is_base  = (name == "addu") || (name == "subu") || (name == "ori") || (name == "lui") ||
                   (name == "lw") || (name == "sw") || (name == "beq") || (name == "blez") ||
                   (name == "jr") || (name == "jal");
    bit known    = is_base || (is_md && MD_EN);
    bit is_br    = (name == "beq") || (name == "blez") || (name == "jr");
    set_instr(o, f, z, l);
    cycles = 0;
    for (int i = 0; i < fetch_wait; i++) begin
      e = '0; e.mem_read = 1'b1;
      apply_stimulus(e, 1'b0, 1'b0, {name, " fetch-wait"}); cycles++;
    end
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    apply_stimulus(e, 1'b1, 1'b0, {name, " fetch"}); cycles++;

    e = '0; e.st = 3'd1;
    if (name == "jal") begin
      e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b11;
      e.pc_write = 1'b1; e.npc_sel = 2'b10;
    end else if (!known) begin
      e.ill = 1'b1;
    end
    apply_stimulus(e, 1'($urandom_range(0, 1)), 1'b0, {name, " decode"}); cycles++;
    if (name == "jal" || !known) return;

    e = '0; e.st = 3'd2;
    if (name == "addu") e.alu_ctrl = 3'b010;
    if (name == "subu") e.alu_ctrl = 3'b011;
    if (name == "ori") begin e.alu_src = 1'b1; e.ext_op = 1'b1; e.alu_ctrl = 3'b001; end
    if (name == "lw" || name == "sw") begin e.alu_src = 1'b1; e.alu_ctrl = 3'b010; end
    if (name == "beq") begin e.alu_ctrl = 3'b011; e.pc_write = z; e.npc_sel = 2'b01; end
    if (name == "blez") begin e.pc_write = l; e.npc_sel = 2'b01; end
    if (name == "jr") begin e.pc_write = 1'b1; e.npc_sel = 2'b11; end
    if (name == "mult") e.md_op = 2'b01;
    if (name == "div")  e.md_op = 2'b10;
    apply_stimulus(e, 1'($urandom_range(0, 1)), 1'b0, {name, " exec"}); cycles++;
    if (is_br) return;

    if (name == "mult" || name == "div") begin
      for (int i = 0; i < ((name == "mult") ? MULT_N : DIV_N); i++) begin
        e = '0; e.st = 3'd5;
        apply_stimulus(e, 1'($urandom_range(0, 1)), 1'b0, {name, " mdwait"}); cycles++;
      end
      return;
    end

    if (name == "lw" || name == "sw") begin
      for (int i = 0; i <= mem_wait; i++) begin
        e = '0; e.st = 3'd3;
        e.mem_read  = (name == "lw");
        e.mem_write = (name == "sw");
        apply_stimulus(e, (i == mem_wait), 1'b0, {name, " mem"}); cycles++;
      end
      if (name == "sw") return;
    end

    e = '0; e.st = 3'd4; e.reg_write = 1'b1;
    e.reg_dst = (name == "addu" || name == "subu" || name == "mfhi" || name == "mflo") ? 2'b01 : 2'b00;
    e.mem_to_reg = (name == "lw") ? 2'b10 : (name == "lui") ? 2'b01 : 2'b00;
    e.hilo_rd = (name == "mfhi") ? 2'b10 : (name == "mflo") ? 2'b01 : 2'b00;
    apply_stimulus(e, 1'($urandom_range(0, 1)), 1'b0, {name, " wb"}); cycles++;
  endtask

  initial begin
    int   n;
    obs_t z0;
    z0 = '0;
    for (int i = 0; i < 3; i++) apply_stimulus(z0, 1'b1, 1'b1, "reset hold");

    run_instr("addu", 6'b000000, 6'b100001, 0, 0, 1'b0, 1'b0, n);
    check_output("cycles addu", n, 4);
    run_instr("lw", 6'b100011, 6'b010101, 0, 2, 1'b0, 1'b0, n);
    check_output("cycles lw stalled", n, 7);
    run_instr("beq", 6'b000100, 6'b000000, 0, 0, 1'b0, 1'b1, n);
    check_output("cycles beq", n, 3);
    run_instr("beq", 6'b000100, 6'b000000, 0, 0, 1'b1, 1'b0, n);
    run_instr("blez", 6'b000110, 6'b000000, 1, 0, 1'b1, 1'b1, n);
    run_instr("blez", 6'b000110, 6'b000000, 0, 0, 1'b1, 1'b0, n);
    run_instr("jr", 6'b000000, 6'b001000, 0, 0, 1'b0, 1'b0, n);
    run_instr("subu", 6'b000000, 6'b100011, 0, 0, 1'b1, 1'b1, n);
    run_instr("ori", 6'b001101, 6'b100001, 0, 0, 1'b0, 1'b1, n);
    run_instr("lui", 6'b001111, 6'b000000, 0, 0, 1'b1, 1'b0, n);
    run_instr("sw", 6'b101011, 6'b000000, 0, 1, 1'b0, 1'b0, n);
    check_output("cycles sw one wait", n, 5);
    run_instr("mult", 6'b000000, 6'b011000, 0, 0, 1'b0, 1'b0, n);
    check_output("cycles mult", n, MD_EN ? 8 : 2);
    run_instr("div", 6'b000000, 6'b011010, 0, 0, 1'b0, 1'b0, n);
    check_output("cycles div", n, MD_EN ? 6 : 2);
    run_instr("mfhi", 6'b000000, 6'b010000, 0, 0, 1'b0, 1'b0, n);
    run_instr("mflo", 6'b000000, 6'b010010, 0, 0, 1'b0, 1'b0, n);
    run_instr("bad-op", 6'b111111, 6'b100001, 0, 0, 1'b0, 1'b0, n);
    run_instr("bad-func", 6'b000000, 6'b111111, 0, 0, 1'b0, 1'b0, n);
    run_instr("jal", 6'b000011, 6'b000000, 0, 0, 1'b0, 1'b0, n);
    check_output("cycles jal", n, 2);

    // sw aborted by reset while in DECODE
    set_instr(6'b101011, 6'b000000, 1'b0, 1'b0);
    begin
      obs_t e;
      e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
      apply_stimulus(e, 1'b1, 1'b0, "sw fetch before abort");
    end
    apply_stimulus(z0, 1'b1, 1'b1, "sw abort in decode");
    apply_stimulus(z0, 1'b1, 1'b1, "sw abort hold");
    run_instr("addu", 6'b000000, 6'b100001, 2, 0, 1'b0, 1'b0, n);
    check_output("cycles addu after reset", n, 6);

    @(negedge clk);
    #1;
    check_output("expectation queue drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
